// File: rtl/arp_server_deadlock_report_ctrl_if.sv
// arp_server_deadlock_report_ctrl_if: report beat channel from the deadlock controller to its sink
interface arp_server_deadlock_report_ctrl_if #(
   parameter int NUM_MON = 4,
   parameter int TS_W = 32
);
   localparam int IW = NUM_MON > 2 ? $clog2(NUM_MON) : 1;
   logic rpt_valid;
   logic rpt_ready;
   logic [IW-1:0] rpt_idx;
   logic [NUM_MON-1:0] rpt_mask;
   logic [TS_W-1:0] rpt_ts;
   modport master (output rpt_valid, rpt_idx, rpt_mask, rpt_ts, input rpt_ready);
   modport slave (input rpt_valid, rpt_idx, rpt_mask, rpt_ts, output rpt_ready);
endinterface

// File: rtl/arp_server_deadlock_report_ctrl.sv
// arp_server_deadlock_report_ctrl: confirms sustained region blocking as deadlock and reports each blocked monitor
module arp_server_deadlock_report_ctrl #(
   parameter int NUM_MON = 4,
   parameter int CONFIRM_CYC = 16,
   parameter int TS_W = 32
) (
   input logic clock,
   input logic reset,
   input logic enable,
   input logic [NUM_MON-1:0] block_in,
   input logic clear,
   output logic deadlock,
   output logic [7:0] event_cnt,
   arp_server_deadlock_report_ctrl_if.master rpt
);
   localparam int IW = NUM_MON > 2 ? $clog2(NUM_MON) : 1;
   typedef enum logic [2:0] {IDLE, WATCH, CONFIRM, REPORT, HOLD} state_t;
   state_t state;
   logic [TS_W-1:0] ts;
   logic [15:0] cnt;
   logic [NUM_MON-1:0] pending;
   logic [NUM_MON-1:0] pending_left;
   logic any_block;
   function automatic logic [IW-1:0] lowest(input logic [NUM_MON-1:0] v);
      lowest = '0;
      for (int i = NUM_MON - 1; i >= 0; i--) if (v[i]) lowest = IW'(i);
   endfunction
   assign any_block = |block_in;
   assign pending_left = pending & ~(NUM_MON'(1) << rpt.rpt_idx);
   // The first blocked cycle is sampled in WATCH, so CONFIRM fires when cnt reaches CONFIRM_CYC-1
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= IDLE;
         ts <= '0;
         cnt <= '0;
         pending <= '0;
         deadlock <= 1'b0;
         event_cnt <= '0;
         rpt.rpt_valid <= 1'b0;
         rpt.rpt_idx <= '0;
         rpt.rpt_mask <= '0;
         rpt.rpt_ts <= '0;
      end else begin
         ts <= ts + 1'b1;
         case (state)
            IDLE: if (enable) state <= WATCH;
            WATCH:
               if (!enable) state <= IDLE;
               else if (any_block) begin
                  state <= CONFIRM;
                  cnt <= 16'd1;
               end
            CONFIRM:
               if (!enable) state <= IDLE;
               else if (clear || !any_block) state <= WATCH;
               else if (cnt == 16'(CONFIRM_CYC - 1)) begin
                  state <= REPORT;
                  pending <= block_in;
                  rpt.rpt_mask <= block_in;
                  rpt.rpt_ts <= ts;
                  rpt.rpt_idx <= lowest(block_in);
                  rpt.rpt_valid <= 1'b1;
                  deadlock <= 1'b1;
                  event_cnt <= event_cnt == 8'hFF ? event_cnt : event_cnt + 1'b1;
               end else cnt <= cnt + 1'b1;
            REPORT:
               if (rpt.rpt_ready) begin
                  pending <= pending_left;
                  if (|pending_left) rpt.rpt_idx <= lowest(pending_left);
                  else begin
                     rpt.rpt_valid <= 1'b0;
                     state <= HOLD;
                  end
               end
            HOLD:
               if (clear) begin
                  deadlock <= 1'b0;
                  state <= enable ? WATCH : IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_arp_server_deadlock_report_ctrl.sv
// tb_arp_server_deadlock_report_ctrl: directed checks of confirmation, reporting, clear, saturation, reset abort and ts wrap
module tb_arp_server_deadlock_report_ctrl;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;
   logic enable = 1'b0, clear = 1'b0;
   logic [3:0] block_in = '0;
   logic deadlock;
   logic [7:0] event_cnt;
   logic enable2 = 1'b0, clear2 = 1'b0;
   logic [3:0] block2 = '0;
   logic deadlock2;
   logic [7:0] event_cnt2;
   int n_assert = 0, n_fail = 0, cyc = 0;
   logic [31:0] saved_ts;
   arp_server_deadlock_report_ctrl_if #(.NUM_MON(4), .TS_W(32)) rpt ();
   arp_server_deadlock_report_ctrl_if #(.NUM_MON(4), .TS_W(4)) rpt2 ();
   arp_server_deadlock_report_ctrl dut (
      .clock(clock), .reset(reset), .enable(enable), .block_in(block_in), .clear(clear),
      .deadlock(deadlock), .event_cnt(event_cnt), .rpt(rpt)
   );
   arp_server_deadlock_report_ctrl #(.CONFIRM_CYC(4), .TS_W(4)) dut2 (
      .clock(clock), .reset(reset), .enable(enable2), .block_in(block2), .clear(clear2),
      .deadlock(deadlock2), .event_cnt(event_cnt2), .rpt(rpt2)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clock);
      #1;
      cyc++;
   endtask
   task automatic run_event;
      clear = 1'b1;
      block_in = '0;
      tick;
      clear = 1'b0;
      block_in = 4'b0100;
      repeat (16) tick;
      tick;
   endtask
   initial begin
      rpt.rpt_ready = 1'b0;
      rpt2.rpt_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_dead", deadlock, 0);
      chk("rst_valid", rpt.rpt_valid, 0);
      chk("rst_idx", rpt.rpt_idx, 0);
      chk("rst_mask", rpt.rpt_mask, 0);
      chk("rst_ts", rpt.rpt_ts, 0);
      chk("rst_evt", event_cnt, 0);
      reset = 1'b0;
      cyc = 0;
      tick;
      tick;
      chk("idle_valid", rpt.rpt_valid, 0);
      // single-bit deadlock, ready held high
      enable = 1'b1;
      tick;
      block_in = 4'b0010;
      rpt.rpt_ready = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick;
         chk("a_wait", rpt.rpt_valid, 0);
      end
      tick;
      chk("a_valid", rpt.rpt_valid, 1);
      chk("a_dead", deadlock, 1);
      chk("a_idx", rpt.rpt_idx, 1);
      chk("a_mask", rpt.rpt_mask, 4'b0010);
      chk("a_ts", rpt.rpt_ts, 64'(cyc - 1));
      chk("a_evt", event_cnt, 1);
      tick;
      chk("a_done", rpt.rpt_valid, 0);
      chk("a_dead2", deadlock, 1);
      repeat (3) tick;
      chk("a_hold_valid", rpt.rpt_valid, 0);
      chk("a_hold_dead", deadlock, 1);
      // two-bit deadlock with a stalled sink
      clear = 1'b1;
      block_in = '0;
      tick;
      clear = 1'b0;
      chk("b_clr", deadlock, 0);
      block_in = 4'b1010;
      rpt.rpt_ready = 1'b0;
      repeat (16) tick;
      chk("b_valid", rpt.rpt_valid, 1);
      chk("b_idx", rpt.rpt_idx, 1);
      chk("b_mask", rpt.rpt_mask, 4'b1010);
      chk("b_ts", rpt.rpt_ts, 64'(cyc - 1));
      chk("b_evt", event_cnt, 2);
      saved_ts = rpt.rpt_ts;
      for (int i = 2; i <= 5; i++) begin
         block_in = '0;
         clear = (i == 3);
         enable = (i != 4);
         tick;
         chk("b_stall_valid", rpt.rpt_valid, 1);
         chk("b_stall_idx", rpt.rpt_idx, 1);
         chk("b_stall_mask", rpt.rpt_mask, 4'b1010);
         chk("b_stall_ts", rpt.rpt_ts, 64'(saved_ts));
      end
      clear = 1'b0;
      enable = 1'b1;
      rpt.rpt_ready = 1'b1;
      tick;
      chk("b2_valid", rpt.rpt_valid, 1);
      chk("b2_idx", rpt.rpt_idx, 3);
      chk("b2_mask", rpt.rpt_mask, 4'b1010);
      chk("b2_ts", rpt.rpt_ts, 64'(saved_ts));
      tick;
      chk("b_done", rpt.rpt_valid, 0);
      chk("b_dead", deadlock, 1);
      // interrupted blocking never confirms
      clear = 1'b1;
      tick;
      clear = 1'b0;
      chk("c_clr", deadlock, 0);
      block_in = 4'b0001;
      repeat (15) begin
         tick;
         chk("c_run1", rpt.rpt_valid, 0);
      end
      block_in = '0;
      tick;
      block_in = 4'b0001;
      repeat (15) begin
         tick;
         chk("c_run2", rpt.rpt_valid, 0);
      end
      block_in = '0;
      tick;
      chk("c_dead", deadlock, 0);
      chk("c_evt", event_cnt, 2);
      // enable drop at cnt=10 discards the count
      block_in = 4'b0001;
      repeat (10) tick;
      enable = 1'b0;
      tick;
      chk("d_off", rpt.rpt_valid, 0);
      repeat (2) tick;
      enable = 1'b1;
      tick;
      repeat (15) begin
         tick;
         chk("d_wait", rpt.rpt_valid, 0);
      end
      tick;
      chk("d_valid", rpt.rpt_valid, 1);
      chk("d_idx", rpt.rpt_idx, 0);
      chk("d_mask", rpt.rpt_mask, 4'b0001);
      chk("d_ts", rpt.rpt_ts, 64'(cyc - 1));
      chk("d_evt", event_cnt, 3);
      tick;
      chk("d_done", rpt.rpt_valid, 0);
      // event counter saturation
      repeat (252) run_event;
      chk("e_evt255", event_cnt, 255);
      repeat (2) run_event;
      chk("e_sat", event_cnt, 255);
      chk("e_dead", deadlock, 1);
      // reset in the middle of a stalled report
      clear = 1'b1;
      block_in = '0;
      tick;
      clear = 1'b0;
      block_in = 4'b1100;
      rpt.rpt_ready = 1'b0;
      repeat (16) tick;
      chk("f_valid", rpt.rpt_valid, 1);
      chk("f_idx", rpt.rpt_idx, 2);
      #2 reset = 1'b1;
      #1;
      chk("f_rst_valid", rpt.rpt_valid, 0);
      chk("f_rst_dead", deadlock, 0);
      chk("f_rst_idx", rpt.rpt_idx, 0);
      chk("f_rst_mask", rpt.rpt_mask, 0);
      chk("f_rst_ts", rpt.rpt_ts, 0);
      chk("f_rst_evt", event_cnt, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      cyc = 0;
      enable = 1'b0;
      block_in = '0;
      repeat (5) begin
         tick;
         chk("f_after", rpt.rpt_valid, 0);
      end
      // 4-bit timestamp wraps past 15
      repeat (14) tick;
      enable2 = 1'b1;
      tick;
      block2 = 4'b1000;
      repeat (3) tick;
      chk("g_wait", rpt2.rpt_valid, 0);
      tick;
      chk("g_valid", rpt2.rpt_valid, 1);
      chk("g_idx", rpt2.rpt_idx, 3);
      chk("g_ts", rpt2.rpt_ts, 64'((cyc - 1) % 16));
      chk("g_evt", event_cnt2, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/arp_server_deadlock_report_ctrl.md
ARP_SERVER_DEADLOCK_REPORT_CTRL -- requirements
Module: arp_server_deadlock_report_ctrl

Interface
REQ-001 Parameter NUM_MON, default 4: number of per-region deadlock monitor block inputs; legal range 2..16.
REQ-002 Parameter CONFIRM_CYC, default 16: consecutive blocked cycles needed to declare deadlock; legal range 2..65535.
REQ-003 Parameter TS_W, default 32: timestamp width.
REQ-004 Port clock  in  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  in  1: reset, asynchronous and active-high.
REQ-006 Port enable  in  1: arms monitoring when high.
REQ-007 Port block_in  in  NUM_MON: per-monitor block flags, one per region monitor.
REQ-008 Port clear  in  1: single-cycle pulse that re-arms after a latched deadlock.
REQ-009 Port deadlock  out  1: sticky deadlock flag.
REQ-010 Port rpt_valid  out  1: report beat valid.
REQ-011 Port rpt_ready  in  1: report beat accepted by the sink.
REQ-012 Port rpt_idx  out  max(1,$clog2(NUM_MON)): index of the reported monitor.
REQ-013 Port rpt_mask  out  NUM_MON: snapshot of block_in at confirmation.
REQ-014 Port rpt_ts  out  TS_W: timestamp at confirmation.
REQ-015 Port event_cnt  out  8: count of confirmed deadlock events.

Function
REQ-016 Free-running ts counter shall increment every cycle, wrap 2^TS_W-1 -> 0.
REQ-017 FSM states: IDLE, WATCH, CONFIRM, REPORT, HOLD.
REQ-018 IDLE: enable=1 -> WATCH next cycle; otherwise stay.
REQ-019 WATCH: enable=0 -> IDLE; else |block_in=1 -> CONFIRM with cnt=1.
REQ-020 CONFIRM: enable=0 or clear=1 -> IDLE/WATCH respectively (clear takes WATCH, enable=0 wins); |block_in=0 -> WATCH, cnt discarded; else cnt+1.
REQ-021 CONFIRM with |block_in=1 and cnt==CONFIRM_CYC-1 -> REPORT; on that same edge latch pending=block_in, rpt_mask=block_in, rpt_ts=ts, set deadlock=1, increment event_cnt.
REQ-022 Latency: rpt_valid and deadlock rise on the edge that samples the CONFIRM_CYC-th consecutive cycle with any block_in bit high.
REQ-023 REPORT: rpt_valid=1; rpt_idx = lowest set bit index of pending.
REQ-024 REPORT handshake: on rpt_valid&rpt_ready clear that bit of pending; if the remaining pending is nonzero, stay in REPORT and present the next-lowest index the following cycle; else go to HOLD with rpt_valid=0.
REQ-025 While rpt_valid=1 and rpt_ready=0, rpt_idx, rpt_mask and rpt_ts shall hold stable; rpt_valid shall not drop without a handshake.
REQ-026 REPORT ignores enable, clear and block_in changes.
REQ-027 HOLD: deadlock stays 1; clear=1 -> deadlock=0 and go to WATCH if enable=1, else IDLE.
REQ-028 event_cnt shall saturate at 255.
REQ-029 rpt_mask, rpt_ts and rpt_idx hold their last values outside REPORT.

Reset
REQ-030 reset=1 immediately sets state=IDLE, deadlock=0, rpt_valid=0, rpt_idx=0, rpt_mask=0, rpt_ts=0, event_cnt=0, ts=0, cnt=0, pending=0.
REQ-031 reset asserted mid-REPORT aborts the report with no further beats.
REQ-032 After reset deasserts, the first state change is IDLE->WATCH on the first edge with enable=1.

Verification
REQ-033 Defaults; enable=1; block_in=4'b0010 held 20 cycles; rpt_ready=1 -> rpt_valid high exactly 16 sampled block cycles after the first; one beat rpt_idx=1, rpt_mask=0010; deadlock=1; event_cnt=1; HOLD.
REQ-034 block_in=4'b1010 held until confirm; rpt_ready held 0 for 5 cycles, then 1 -> beat idx=1 stable for all 6 cycles, then beat idx=3, both with mask=1010 and the same rpt_ts, then HOLD.
REQ-035 block_in high 15 cycles, low 1 cycle, high 15 cycles -> no deadlock, no rpt_valid, event_cnt=0.
REQ-036 In HOLD, pulse clear with enable=1 -> deadlock=0, WATCH; repeat the event 256 times -> event_cnt=255 (saturated).
REQ-037 Assert reset during REPORT with rpt_ready=0 -> all outputs 0 on the same edge; no beat after release.
REQ-038 enable dropped at cnt=10 in CONFIRM -> IDLE, no report; ts wraps correctly with TS_W=4.
